// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with same-cycle write bypass and a per-register
// pending scoreboard; x0 reads as zero and is never pending.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rs_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]    rs_data,
    output logic [NUM_RD-1:0]              rs_ready,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data,
    input  logic                           issue_en,
    input  logic [ADDR_W-1:0]              issue_addr,
    output logic [NUM_REGS-1:0]            pending,
    output logic [CNT_W-1:0]               pending_cnt
);

    logic [XLEN-1:0]       r_regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   r_pend;
    logic [CNT_W-1:0]      r_cnt;

    logic [NUM_REGS-1:1]   w_wrHit;
    logic [XLEN-1:0]       w_wrVal [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   w_pendNext;
    logic [CNT_W-1:0]      w_cntNext;
    logic [XLEN-1:0]       w_regsFull [NUM_REGS];
    logic [NUM_REGS-1:0]   w_pendFull;

    // Later write ports override earlier ones targeting the same register.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            w_wrHit[r] = 1'b0;
            w_wrVal[r] = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_addr[p] == ADDR_W'(r))) begin
                    w_wrHit[r] = 1'b1;
                    w_wrVal[r] = wr_data[p];
                end
            end
        end
    end

    // Issue takes priority over a writeback clear so a new producer stays tracked.
    always_comb begin
        w_cntNext = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_pendNext[r] = (issue_en && (issue_addr == ADDR_W'(r))) ||
                            (r_pend[r] && !w_wrHit[r]);
            w_cntNext     = w_cntNext + CNT_W'(w_pendNext[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_wrHit[r]) begin
                    r_regs[r] <= w_wrVal[r];
                end
            end
            r_pend <= w_pendNext;
            r_cnt  <= w_cntNext;
        end
    end

    always_comb begin
        w_regsFull[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_regsFull[r] = r_regs[r];
        end
    end

    assign w_pendFull  = {r_pend, 1'b0};
    assign pending     = w_pendFull;
    assign pending_cnt = r_cnt;

    // Reset gates the bypass too, so reads are zero/ready while rst is held low.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rs_data[i]  = '0;
            rs_ready[i] = 1'b1;
            if (rst && (rs_addr[i] != '0) && (int'(rs_addr[i]) < NUM_REGS)) begin
                rs_data[i]  = w_regsFull[rs_addr[i]];
                rs_ready[i] = !w_pendFull[rs_addr[i]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (wr_en[p] && (wr_addr[p] == rs_addr[i])) begin
                            rs_data[i]  = wr_data[p];
                            rs_ready[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: a bypassing and a non-bypassing register file share stimulus and
// are checked against hand-computed values at each step.
module tb_regfile_mp_sb;

   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam int NUM_RD   = 2;
   localparam int NUM_WR   = 2;
   localparam int ADDR_W   = $clog2(NUM_REGS);
   localparam int CNT_W    = $clog2(NUM_REGS + 1);

   logic                          clk;
   logic                          rst;
   logic [NUM_RD-1:0][ADDR_W-1:0] rsAddr;
   logic [NUM_WR-1:0]             wrEn;
   logic [NUM_WR-1:0][ADDR_W-1:0] wrAddr;
   logic [NUM_WR-1:0][XLEN-1:0]   wrData;
   logic                          issueEn;
   logic [ADDR_W-1:0]             issueAddr;

   logic [NUM_RD-1:0][XLEN-1:0]   rsDataB, rsDataN;
   logic [NUM_RD-1:0]             rsReadyB, rsReadyN;
   logic [NUM_REGS-1:0]           pendingB, pendingN;
   logic [CNT_W-1:0]              cntB, cntN;

   int vectors;
   int miscompares;

   regfile_mp_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(1)) dutB (
      .clk(clk), .rst(rst),
      .rs_addr(rsAddr), .rs_data(rsDataB), .rs_ready(rsReadyB),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .issue_en(issueEn), .issue_addr(issueAddr),
      .pending(pendingB), .pending_cnt(cntB)
   );

   regfile_mp_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(0)) dutN (
      .clk(clk), .rst(rst),
      .rs_addr(rsAddr), .rs_data(rsDataN), .rs_ready(rsReadyN),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .issue_en(issueEn), .issue_addr(issueAddr),
      .pending(pendingN), .pending_cnt(cntN)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, and report a failing one with its tag.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of inputs, then let them settle before checks.
   task automatic applyStimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra0, input logic [4:0] ra1);
      wrEn      = we;
      wrAddr[0] = wa0;
      wrData[0] = wd0;
      wrAddr[1] = wa1;
      wrData[1] = wd1;
      issueEn   = ie;
      issueAddr = ia;
      rsAddr[0] = ra0;
      rsAddr[1] = ra1;
      #1;
   endtask

   // Advance past the next rising edge; sample well away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);

      // Reset state
      tick();
      checkOutput("reset rs_data", rsDataB[0], 32'h0);
      checkOutput("reset rs_ready", 32'(rsReadyB), 32'h3);
      checkOutput("reset pending", pendingB, 32'h0);
      checkOutput("reset cnt", 32'(cntB), 32'h0);
      #2 rst = 1'b1;
      tick();

      // x0: write and issue to x0 are ignored
      applyStimulus(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      checkOutput("x0 bypass data", rsDataB[0], 32'h0);
      checkOutput("x0 ready", 32'(rsReadyB[0]), 32'h1);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("x0 data after", rsDataB[0], 32'h0);
      checkOutput("x0 pending", pendingB, 32'h0);
      checkOutput("x0 cnt", 32'(cntB), 32'h0);

      // Both write ports to x7: port 1 wins
      applyStimulus(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 1'b0, 5'd0, 5'd7, 5'd7);
      checkOutput("conflict bypass rd0", rsDataB[0], 32'h2222);
      checkOutput("conflict bypass rd1", rsDataB[1], 32'h2222);
      checkOutput("conflict nobypass old", rsDataN[0], 32'h0);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
      checkOutput("conflict stored B", rsDataB[0], 32'h2222);
      checkOutput("conflict stored N", rsDataN[1], 32'h2222);

      // Scoreboard: issue x3, then writeback x3 on port 1
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
      checkOutput("issue cycle ready", 32'(rsReadyB[0]), 32'h1);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
      checkOutput("x3 not ready B", 32'(rsReadyB[0]), 32'h0);
      checkOutput("x3 not ready N", 32'(rsReadyN[0]), 32'h0);
      checkOutput("x3 pending", pendingB, 32'h0000_0008);
      checkOutput("x3 cnt", 32'(cntB), 32'h1);
      applyStimulus(2'b10, 5'd0, 32'h0, 5'd3, 32'h55, 1'b0, 5'd0, 5'd3, 5'd0);
      checkOutput("wb bypass ready", 32'(rsReadyB[0]), 32'h1);
      checkOutput("wb bypass data", rsDataB[0], 32'h55);
      checkOutput("wb nobypass ready", 32'(rsReadyN[0]), 32'h0);
      checkOutput("wb nobypass data", rsDataN[0], 32'h0);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
      checkOutput("wb cnt after", 32'(cntB), 32'h0);
      checkOutput("wb ready after N", 32'(rsReadyN[0]), 32'h1);
      checkOutput("wb data after N", rsDataN[0], 32'h55);

      // Issue x9, then issue + writeback of x9 together, plus new x10 issue+writeback
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd10);
      tick();
      checkOutput("x9 cnt", 32'(cntB), 32'h1);
      applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd10);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd10);
      checkOutput("x9 still pending", pendingB, 32'h0000_0200);
      checkOutput("x9 cnt unchanged", 32'(cntB), 32'h1);
      checkOutput("x9 data", rsDataB[0], 32'h99);
      checkOutput("x9 not ready", 32'(rsReadyB[0]), 32'h0);
      applyStimulus(2'b10, 5'd0, 32'h0, 5'd10, 32'hAA, 1'b1, 5'd10, 5'd9, 5'd10);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd10);
      checkOutput("x10 pending", pendingB, 32'h0000_0600);
      checkOutput("x10 cnt", 32'(cntN), 32'h2);
      checkOutput("x10 data", rsDataN[1], 32'hAA);

      // WAW: re-issue already-pending x10
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd9, 5'd10);
      tick();
      checkOutput("waw cnt", 32'(cntB), 32'h2);

      // Non-bypass: x4 pending then written
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd4);
      tick();
      applyStimulus(2'b01, 5'd4, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4);
      checkOutput("x4 N old data", rsDataN[1], 32'h0);
      checkOutput("x4 N pre-edge ready", 32'(rsReadyN[1]), 32'h0);
      checkOutput("x4 B bypass data", rsDataB[1], 32'hA5);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4);
      checkOutput("x4 N next data", rsDataN[1], 32'hA5);
      checkOutput("x4 N next ready", 32'(rsReadyN[1]), 32'h1);
      checkOutput("cnt before reset", 32'(cntB), 32'h2);

      // Asynchronous reset mid-cycle wipes stored data and scoreboard
      applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
      checkOutput("x5 stored", rsDataN[0], 32'hDEADBEEF);
      #2 rst = 1'b0;
      #1;
      checkOutput("async rst data B", rsDataB[0], 32'h0);
      checkOutput("async rst data N", rsDataN[0], 32'h0);
      checkOutput("async rst ready", 32'(rsReadyN), 32'h3);
      checkOutput("async rst pending", pendingB, 32'h0);
      checkOutput("async rst cnt", 32'(cntN), 32'h0);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("post rst data", rsDataB[0], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port integer register file with write-to-read bypass and a per-register pending scoreboard, replacing the single-write, two-read register file in the pipelined core. Decode reads operands and marks destination registers pending at issue; writeback ports clear pending bits and update contents. x0 is hardwired to zero and never pending.

## Interface
- XLEN, 32, register width in bits
- NUM_REGS, 32, number of architectural registers, including x0
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write (writeback) ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see pre-edge contents
- ADDR_W, $clog2(NUM_REGS), register address width
- CNT_W, $clog2(NUM_REGS+1), pending counter width
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- rs_addr  in  NUM_RD x ADDR_W  read addresses
- rs_data  out  NUM_RD x XLEN  read data (combinational)
- rs_ready  out  NUM_RD  operand valid: register not pending, or cleared by writeback this cycle when BYPASS=1
- wr_en  in  NUM_WR  write strobes
- wr_addr  in  NUM_WR x ADDR_W  write addresses
- wr_data  in  NUM_WR x XLEN  write data
- issue_en  in  1  mark issue_addr pending at the next edge
- issue_addr  in  ADDR_W  destination register of the issuing instruction
- pending  out  NUM_REGS  scoreboard bit vector, registered; bit 0 is always 0
- pending_cnt  out  CNT_W  population count of pending, registered

## Operation
- Storage: NUM_REGS-1 XLEN-bit registers (x1..x(NUM_REGS-1)) and NUM_REGS-1 pending bits. x0 has no storage: reads return 0, writes are dropped, issue to x0 is ignored, pending[0]=0, and rs_ready is 1.
- Write: on the edge, each register takes wr_data of the highest-index port with wr_en set and a matching wr_addr. Lower-index ports targeting the same register are discarded.
- Writeback clear: any enabled write port to register r clears pending[r] at the edge.
- Issue: issue_en sets pending[issue_addr] at the edge.
  - Issue and writeback to the same r in the same cycle: issue wins, so pending[r] stays or becomes 1 (new producer). The data write still occurs.
  - Issue to an already-pending register (WAW) leaves pending at 1, and the count is unchanged.
- pending_cnt: tracks the population of pending exactly, updated at the same edge as pending. Its range is 0..NUM_REGS-1 and it never wraps.
- Read, BYPASS=1: if any enabled write port targets rs_addr (≠0) this cycle, rs_data is the highest-index matching wr_data and rs_ready=1. Otherwise rs_data is the stored value and rs_ready=!pending[rs_addr].
- Read, BYPASS=0: rs_data is the stored value and rs_ready=!pending[rs_addr], both pre-edge.
- Read ports are independent; any number of them may address the same register.

## Timing
- Reset (rst=0, asynchronous): all registers 0, pending=0, pending_cnt=0. During and after reset, every rs_data=0 and rs_ready=1.
- Release of rst is synchronised externally; the block takes no action on the first edge after release other than normal operation.
- Write latency: 1 edge to storage. With BYPASS=1, data is visible on reads in the same cycle; with BYPASS=0, it is visible the cycle after the edge.
- Issue latency: pending and rs_ready change at the edge after issue_en. A read in the issue cycle still sees the old state.
- Read path: purely combinational from rs_addr, wr_* and state, with no added latency.
- Reset asserted mid-operation: all state clears immediately, regardless of clk. In-flight writes and issues in that cycle are lost.

## Test plan
- Reset: write x5=0xDEADBEEF, then pulse rst low between edges → rs_data[0] for addr 5 reads 0 immediately; pending=0, pending_cnt=0.
- x0: wr_en to x0 with 0xFFFFFFFF plus issue to x0 → reads of x0 return 0, rs_ready=1, pending[0]=0, pending_cnt unchanged.
- Port conflict: both write ports to x7, port0=0x1111 and port1=0x2222, with BYPASS=1 → same-cycle read of x7 returns 0x2222, and it still reads 0x2222 after the edge.
- Scoreboard: issue x3 → next cycle rs_ready=0 for x3 and pending_cnt=1. Writeback x3=0x55 → same-cycle rs_ready=1 with data 0x55 (BYPASS=1), and pending_cnt=0 after the edge.
- Simultaneous issue and writeback of x9 → after the edge pending[9]=1, x9 holds the written data, and pending_cnt is unchanged if x9 was already pending.
- BYPASS=0 build: write x4=0xA5 → the same-cycle read returns the old value 0 and rs_ready reflects the pre-edge pending bit; the next cycle returns 0xA5.
